// File: rtl/adpcm_uart_framer_if.sv
// Code intake bus from the CIC/ADPCM compressor.
//   ena        - block enable (gates code intake only)
//   code_valid - one-cycle strobe qualifying code_in
//   code_in    - 4-bit ADPCM code
interface adpcm_uart_framer_if;
  logic       ena;
  logic       code_valid;
  logic [3:0] code_in;

  modport master (output ena, output code_valid, output code_in);
  modport slave  (input  ena, input  code_valid, input  code_in);
endinterface

// File: rtl/adpcm_uart_framer.sv
// Packs pairs of 4-bit ADPCM codes into bytes, buffers them in a byte FIFO
// and sends them out as an 8N1 UART stream.
//   clk, rst_n  - clock, synchronous active-low reset
//   code_if     - code intake bus (ena, code_valid, code_in)
//   tx          - UART serial output, idle high
//   busy        - high while a frame is in START/DATA/STOP
//   overflow    - sticky, a packed byte was dropped on a full FIFO
//   fifo_level  - current FIFO occupancy
module adpcm_uart_framer #(
  parameter int unsigned CLK_DIV    = 104,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  adpcm_uart_framer_if.slave            code_if,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state;
  logic            phase;
  logic [3:0]      hi_nib;
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   baud_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;

  logic            push_c;
  logic            pop_c;
  logic            full_c;
  logic            wr_en_c;
  logic            baud_last_c;

  // A completed byte exists on the second accepted code of a pair.
  assign push_c      = code_if.ena & code_if.code_valid & phase;
  assign pop_c       = (state == IDLE) && (fifo_level != LW'(0));
  assign full_c      = (fifo_level == LW'(FIFO_DEPTH));
  // A simultaneous pop frees the head slot, so a push on full still lands.
  assign wr_en_c     = push_c & (~full_c | pop_c);
  assign baud_last_c = (baud_cnt == CW'(CLK_DIV - 1));

  // Nibble packer; dropping ena discards a pending high nibble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase  <= 1'b0;
      hi_nib <= 4'h0;
    end else if (!code_if.ena) begin
      phase  <= 1'b0;
    end else if (code_if.code_valid) begin
      if (!phase) begin
        hi_nib <= code_if.code_in;
        phase  <= 1'b1;
      end else begin
        phase  <= 1'b0;
      end
    end
  end

  // FIFO storage; contents need no reset, pointers and level define validity.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      fifo_mem[wr_ptr] <= {hi_nib, code_if.code_in};
    end
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en_c, pop_c})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (push_c && full_c && !pop_c) begin
        overflow <= 1'b1;
      end
    end
  end

  // UART transmitter; tx and busy are registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= 3'd0;
      shreg    <= 8'h00;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          busy     <= 1'b0;
          baud_cnt <= '0;
          if (pop_c) begin
            shreg <= fifo_mem[rd_ptr];
            state <= START;
            tx    <= 1'b0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (baud_last_c) begin
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            tx       <= shreg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        DATA: begin
          if (baud_last_c) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              // Next data bit sits at shreg[1] before the shift takes effect.
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        STOP: begin
          if (baud_last_c) begin
            baud_cnt <= '0;
            busy     <= 1'b0;
            tx       <= 1'b1;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
